accel_sequencer: RTL and testbench
==================================

Name: accel_sequencer

Overview:
Parametrised control sequencer for the systolic-array accelerator datapath. It replaces externally driven buffer and array enables with an internal FSM. One start/done job handshake runs the full sequence: weight load, weight preload, activation load, compute, drain, and handshaked result readout. It sits beside the datapath top and drives every buffer, array and post-processing enable.

Parameters:
ARRAY_W, 8, array dimension N (rows = columns); sets preload and weight-load length.
K_MAX, 256, maximum activation rows per job.
OUT_LAT, 8, cycles from first input_buffer_out_en to the first valid array output row; also the DRAIN length.
CNT_W, $clog2(K_MAX+2*ARRAY_W+OUT_LAT), phase counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
k_len  in  $clog2(K_MAX+1)  activation rows for this job; latched with start
mode  in  2  post-processing: 00 bypass, 01 relu, 10 softmax, 11 bypass; latched with start
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
weight_buffer_load_en  out  1  weight buffer write strobe
weight_buffer_out_en  out  1  weight buffer read strobe
write_weight_en  out  1  array weight preload
input_buffer_load_en  out  1  activation buffer write strobe
input_buffer_out_en  out  1  activation buffer read strobe
output_buffer_load_en  out  1  result capture strobe
output_buffer_out_en  out  1  result read strobe (= out_valid & out_ready)
relu_en  out  1  relu stage enable
softmax_en  out  1  softmax stage enable
out_valid  out  1  result row available
out_ready  in  1  downstream accepts row

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all outputs 0, counters 0, latched k_len/mode 0. Reset mid-job aborts immediately. No done pulse is generated.
- All outputs are registered or decoded from the registered state and counter. No combinational path from inputs to outputs except output_buffer_out_en from out_ready.
- States and dwell times (N = ARRAY_W, K = latched k_len):
  - IDLE: wait for start.
  - LOAD_W: N cycles; weight_buffer_load_en=1.
  - PRELOAD: N cycles; weight_buffer_out_en=1 and write_weight_en=1.
  - LOAD_A: K cycles; input_buffer_load_en=1.
  - COMPUTE: K+N-1 cycles (skewed injection); input_buffer_out_en=1.
  - DRAIN: OUT_LAT cycles.
  - OUTPUT: ends after K accepted rows.
  - DONE: 1 cycle, done=1, then IDLE.
- output_buffer_load_en is high for K+N-1 consecutive cycles. It starts at COMPUTE cycle index OUT_LAT (0-based, counted from COMPUTE entry) and ends exactly at the last DRAIN cycle.
- OUTPUT phase:
  - out_valid=1 while rows remain.
  - A row is accepted on a cycle with out_valid & out_ready; output_buffer_out_en pulses on that cycle.
  - out_ready low stalls with no loss and no counter advance.
  - relu_en = (mode==01) and softmax_en = (mode==10) are held for the whole OUTPUT state, 0 elsewhere.
- start while busy: ignored; latched values unchanged.
- start with k_len==0: go directly to DONE (done pulses next cycle). No enable is asserted.
- k_len > K_MAX: saturates to K_MAX.
- Mode 11 behaves as bypass.
- A start high in the DONE cycle is ignored. Start is only accepted in IDLE.

Optional Feature:
ACCEL_SEQ_PERF_EN:
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts OUTPUT cycles with out_ready=0.
  - Both clear on an accepted start and on reset, and saturate at all-ones.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - state encoding localparams (IDLE, LOAD_W, PRELOAD, LOAD_A, COMPUTE, DRAIN, OUTPUT, DONE);
  - mode encodings MODE_BYPASS/MODE_RELU/MODE_SOFTMAX;
  - the width-derivation macros.
- One natural sub-module: accel_phase_counter, a loadable down-counter with a zero flag, reused per phase.

Test Plan:
1. Timing, no stall: ARRAY_W=4, OUT_LAT=4, k_len=3, mode=00, out_ready=1, start sampled at edge 0.
   - Enable windows: LOAD_W cycles 1-4, PRELOAD 5-8, LOAD_A 9-11, COMPUTE 12-17, DRAIN 18-21.
   - output_buffer_load_en cycles 16-21; OUTPUT 22-24; done=1 at cycle 25; busy low at 26.
2. Output backpressure: same job, out_ready low on cycles 22-23.
   - output_buffer_out_en exactly 3 pulses, at 24, 25, 26; done at 27.
   - relu_en and softmax_en stay 0.
3. Mode enables: mode=01, then a second job with mode=10.
   - relu_en high only during OUTPUT in job 1; softmax_en only during OUTPUT in job 2.
   - mode changes mid-job have no effect.
4. Reset abort: rst low during cycle 14 of case 1.
   - All outputs 0 within the same cycle; busy=0; no done pulse.
   - A restart after release reproduces case 1 timing exactly.
5. Start edge cases:
   - k_len=0 → done pulse on cycle 1 and no enables at all.
   - start re-asserted at cycle 10 of a running job → ignored; total length unchanged.
   - k_len=300 with K_MAX=256 → LOAD_A lasts 256 cycles.
6. With ACCEL_SEQ_PERF_EN defined, case 2 gives perf_cycles=27 and perf_stalls=2.

Source files
------------

// File: rtl/accel_sequencer_pkg.sv
// Shared encodings for the accelerator sequencer: FSM states, post-processing modes
// and width-derivation helpers.
`ifndef ACCEL_SEQ_WIDTH_MACROS
`define ACCEL_SEQ_WIDTH_MACROS
`define ACCEL_SEQ_KLEN_W(kmax) ($clog2((kmax) + 1))
`define ACCEL_SEQ_CNT_W(kmax, n, lat) ($clog2((kmax) + 2 * (n) + (lat)))
`endif

package accel_sequencer_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_W  = 3'd1;
  localparam logic [2:0] PRELOAD = 3'd2;
  localparam logic [2:0] LOAD_A  = 3'd3;
  localparam logic [2:0] COMPUTE = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;
  localparam logic [2:0] OUTPUT  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam logic [1:0] MODE_BYPASS  = 2'b00;
  localparam logic [1:0] MODE_RELU    = 2'b01;
  localparam logic [1:0] MODE_SOFTMAX = 2'b10;

endpackage

// File: rtl/accel_phase_counter.sv
// Loadable down-counter with zero flag; holds at zero, load has priority over decrement.
module accel_phase_counter
  import accel_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/accel_sequencer.sv
// Job sequencer for the systolic-array datapath: weight load, preload, activation load,
// compute, drain, handshaked readout. Optional ACCEL_SEQ_PERF_EN adds busy/stall counters.
module accel_sequencer
  import accel_sequencer_pkg::*;
#(
  parameter int ARRAY_W = 8,
  parameter int K_MAX   = 256,
  parameter int OUT_LAT = 8,
  parameter int CNT_W   = $clog2(K_MAX + 2 * ARRAY_W + OUT_LAT),
  localparam int KW     = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          weight_buffer_load_en,
  output logic          weight_buffer_out_en,
  output logic          write_weight_en,
  output logic          input_buffer_load_en,
  output logic          input_buffer_out_en,
  output logic          output_buffer_load_en,
  output logic          output_buffer_out_en,
  output logic          relu_en,
  output logic          softmax_en,
  output logic          out_valid,
  input  logic          out_ready
`ifdef ACCEL_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stalls
`endif
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [KW-1:0]    k_reg;
  logic [1:0]       mode_reg;
  logic [KW-1:0]    k_sat;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_dec;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   span;

  assign k_sat   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  // Timed phases always count; OUTPUT only counts accepted rows.
  assign cnt_dec = (state != OUTPUT) || out_ready;

  accel_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_sat == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD_W;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(ARRAY_W - 1);
          end
        end
      end
      LOAD_W: begin
        if (cnt_zero) begin
          state_nxt = PRELOAD;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(ARRAY_W - 1);
        end
      end
      PRELOAD: begin
        if (cnt_zero) begin
          state_nxt = LOAD_A;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(k_reg) - 1'b1;
        end
      end
      LOAD_A: begin
        if (cnt_zero) begin
          state_nxt = COMPUTE;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(k_reg) + CNT_W'(ARRAY_W - 2);
        end
      end
      COMPUTE: begin
        if (cnt_zero) begin
          state_nxt = DRAIN;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(OUT_LAT - 1);
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_nxt = OUTPUT;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(k_reg) - 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready && cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k_reg    <= '0;
      mode_reg <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        k_reg    <= k_sat;
        mode_reg <= mode;
      end
    end
  end

  // Capture window is the last K+N-1 cycles of COMPUTE+DRAIN, decoded from the
  // remaining count: active once at most K+N-2 cycles remain in the combined span.
  assign cnt_ext = (CNT_W + 1)'(cnt);
  assign span    = (CNT_W + 1)'(k_reg) + (CNT_W + 1)'(ARRAY_W) - (CNT_W + 1)'(2);

  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);
  assign weight_buffer_load_en = (state == LOAD_W);
  assign weight_buffer_out_en  = (state == PRELOAD);
  assign write_weight_en       = (state == PRELOAD);
  assign input_buffer_load_en  = (state == LOAD_A);
  assign input_buffer_out_en   = (state == COMPUTE);
  assign output_buffer_load_en = ((state == COMPUTE) && ((cnt_ext + (CNT_W + 1)'(OUT_LAT)) <= span))
                               || ((state == DRAIN) && (cnt_ext <= span));
  assign out_valid             = (state == OUTPUT);
  assign output_buffer_out_en  = out_valid && out_ready;
  assign relu_en               = (state == OUTPUT) && (mode_reg == MODE_RELU);
  assign softmax_en            = (state == OUTPUT) && (mode_reg == MODE_SOFTMAX);

`ifdef ACCEL_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
      if ((state == OUTPUT) && !out_ready && (perf_stalls != '1)) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: table-driven jobs, reset abort, and randomized jobs checked
// cycle by cycle against a phase-window reference model.
module tb_accel_sequencer;

  localparam int N    = 4;
  localparam int L    = 4;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic [1:0]    mode;
  logic          out_ready;
  logic          busy, done, weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic          input_buffer_load_en, input_buffer_out_en, output_buffer_load_en;
  logic          output_buffer_out_en, relu_en, softmax_en, out_valid;
`ifdef ACCEL_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  accel_sequencer #(.ARRAY_W(N), .K_MAX(KMAX), .OUT_LAT(L)) dut (
`ifdef ACCEL_SEQ_PERF_EN
    .perf_cycles           (perf_cycles),
    .perf_stalls           (perf_stalls),
`endif
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .k_len                 (k_len),
    .mode                  (mode),
    .busy                  (busy),
    .done                  (done),
    .weight_buffer_load_en (weight_buffer_load_en),
    .weight_buffer_out_en  (weight_buffer_out_en),
    .write_weight_en       (write_weight_en),
    .input_buffer_load_en  (input_buffer_load_en),
    .input_buffer_out_en   (input_buffer_out_en),
    .output_buffer_load_en (output_buffer_load_en),
    .output_buffer_out_en  (output_buffer_out_en),
    .relu_en               (relu_en),
    .softmax_en            (softmax_en),
    .out_valid             (out_valid),
    .out_ready             (out_ready)
  );

  logic [11:0] dut_v;
  assign dut_v = {busy, done, weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
                  input_buffer_load_en, input_buffer_out_en, output_buffer_load_en,
                  out_valid, output_buffer_out_en, relu_en, softmax_en};

  typedef struct {
    int k; int m; int stall; int restart;
    int exp_done; int exp_acc; int exp_relu; int exp_sm; int exp_load;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Expected outputs for cycle c after the start edge, from the phase windows alone.
  function automatic logic [11:0] model(input int c, input int kk, input int m,
                                        input int acc, input int last, input logic rdy);
    int c0, d0, o0;
    logic outph, dn;
    logic [11:0] v;
    v = '0;
    if (kk == 0) begin
      v[11] = (c == 1);
      v[10] = (c == 1);
      return v;
    end
    c0 = 2 * N + kk + 1;
    d0 = c0 + kk + N - 1;
    o0 = d0 + L;
    outph = (c >= o0) && (acc < kk);
    dn    = (acc == kk) && (c == last + 1);
    v[11] = (c >= 1) && ((c < o0) || outph || dn);
    v[10] = dn;
    v[9]  = (c >= 1) && (c <= N);
    v[8]  = (c > N) && (c <= 2 * N);
    v[7]  = v[8];
    v[6]  = (c > 2 * N) && (c <= 2 * N + kk);
    v[5]  = (c >= c0) && (c < d0);
    v[4]  = (c >= c0 + L) && (c < o0);
    v[3]  = outph;
    v[2]  = outph && rdy;
    v[1]  = outph && (m == 1);
    v[0]  = outph && (m == 2);
    return v;
  endfunction

  task automatic run_job(input int k, input int m, input int stall, input int restart, input bit rnd,
                         output int done_c, output int nout, output int nrelu, output int nsm,
                         output int nload, output int nbusy, output int nstall);
    int c, acc, last, kk, o0;
    bit fin;
    logic rdy;
    logic [11:0] exp_v;
    kk = (k > KMAX) ? KMAX : k;
    o0 = 3 * N + 2 * kk + L;
    acc = 0; last = -10; c = 0; fin = 0; done_c = -1;
    nout = 0; nrelu = 0; nsm = 0; nload = 0; nbusy = 0; nstall = 0;
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(k); mode = 2'(m); out_ready = 1'b1;
    while (!fin) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        start = 1'b0;
        k_len = KW'($urandom);
        mode  = 2'(m ^ 3);
      end
      if (restart > 0 && c == restart) begin
        start = 1'b1; k_len = KW'(7); mode = 2'b01;
      end else if (restart > 0 && c == restart + 1) begin
        start = 1'b0;
      end
      rdy = rnd ? ($urandom_range(0, 3) != 0) : !((c >= o0) && (c < o0 + stall));
      out_ready = rdy;
      @(negedge clk);
      exp_v = model(c, kk, m, acc, last, rdy);
      check($sformatf("cycle%0d_k%0d_m%0d_outputs", c, k, m), int'(dut_v), int'(exp_v));
      if (dut_v[10]) done_c = c;
      nout  += int'(dut_v[2]);
      nrelu += int'(dut_v[1]);
      nsm   += int'(dut_v[0]);
      nload += int'(dut_v[4]);
      nbusy += int'(exp_v[11]);
      if (exp_v[3] && !rdy) nstall++;
      if (exp_v[3] && rdy) begin
        acc++;
        last = c;
      end
      fin = (kk == 0) ? (c >= 2) : ((acc == kk) && (c >= last + 2));
      if (!fin && c >= 6000) begin
        total++; bad++;
        $display("FAIL job_timeout: k=%0d still running at cycle %0d", k, c);
        fin = 1;
      end
    end
    out_ready = 1'b1;
`ifdef ACCEL_SEQ_PERF_EN
    check($sformatf("perf_cycles_k%0d", k), int'(perf_cycles), nbusy);
    check($sformatf("perf_stalls_k%0d", k), int'(perf_stalls), nstall);
`endif
  endtask

  task automatic run_entry(input int i);
    int dc, no, nr, ns, nl, nb, nst;
    run_job(tbl[i].k, tbl[i].m, tbl[i].stall, tbl[i].restart, 1'b0, dc, no, nr, ns, nl, nb, nst);
    check($sformatf("vec%0d_done_cycle", i), dc, tbl[i].exp_done);
    check($sformatf("vec%0d_rows_read", i), no, tbl[i].exp_acc);
    check($sformatf("vec%0d_relu_cycles", i), nr, tbl[i].exp_relu);
    check($sformatf("vec%0d_softmax_cycles", i), ns, tbl[i].exp_sm);
    check($sformatf("vec%0d_capture_cycles", i), nl, tbl[i].exp_load);
  endtask

  initial begin
    int dc, no, nr, ns, nl, nb, nst;
    tbl[0]  = '{3,   0, 0, 0,  25,  3,   0, 0, 6};
    tbl[1]  = '{3,   0, 2, 0,  27,  3,   0, 0, 6};
    tbl[2]  = '{3,   1, 0, 0,  25,  3,   3, 0, 6};
    tbl[3]  = '{3,   2, 0, 0,  25,  3,   0, 3, 6};
    tbl[4]  = '{3,   3, 0, 0,  25,  3,   0, 0, 6};
    tbl[5]  = '{3,   0, 0, 10, 25,  3,   0, 0, 6};
    tbl[6]  = '{3,   1, 0, 25, 25,  3,   3, 0, 6};
    tbl[7]  = '{0,   1, 0, 0,  1,   0,   0, 0, 0};
    tbl[8]  = '{1,   1, 0, 0,  19,  1,   1, 0, 4};
    tbl[9]  = '{5,   2, 3, 0,  34,  5,   0, 8, 8};
    tbl[10] = '{300, 0, 0, 0,  784, 256, 0, 0, 259};

    rst = 1'b0; start = 1'b0; k_len = '0; mode = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(dut_v), 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_entry(i);

    // Abort in COMPUTE: outputs must drop asynchronously and no done may follow.
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(3); mode = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    #1 rst = 1'b0;
    #1 check("abort_outputs_same_cycle", int'(dut_v), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_held_%0d", c), int'(dut_v), 0);
    end
    rst = 1'b1;
    run_entry(0);
    run_entry(2);

    for (int j = 0; j < 12; j++) begin
      run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 0, 0, 1'b1,
              dc, no, nr, ns, nl, nb, nst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
